// File: rtl/change_dispenser_pkg.sv
// ----------------------------------------------------------------------------
// change_dispenser_pkg
// Shared vending-machine definitions used by the change dispenser:
//   - default number of coin types and their default values (100/500/1000)
//   - FSM state encoding
//   - helper for the internal arithmetic width
// Ports: none (package).
// ----------------------------------------------------------------------------
package change_dispenser_pkg;

    localparam int CD_NUM_COINS = 3;
    localparam int COIN_W       = 32;

    // Index 0 is the smallest coin.
    localparam logic [CD_NUM_COINS*COIN_W-1:0] CD_DEFAULT_COIN_VALUES =
        {32'd1000, 32'd500, 32'd100};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SELECT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    // Width used to compare/subtract a 32-bit coin value against the
    // remaining amount. Always at least one bit wider than the amount so
    // the top slice of a difference is never empty.
    function automatic int calc_width(input int total_bits);
        return (total_bits >= COIN_W) ? total_bits + 1 : COIN_W;
    endfunction

endpackage

// File: rtl/change_dispenser_coin_select.sv
// ----------------------------------------------------------------------------
// change_dispenser_coin_select
// Combinational coin chooser: returns the highest-index coin whose value is
// non-zero, not larger than the remaining amount, and currently available.
// Ports:
//   coin_value  packed coin values, index 0 smallest (COIN_W bits each)
//   remaining   remaining amount, zero-extended to CALC_W
//   avail       per-coin availability (inventory non-zero)
//   pick        one-hot chosen coin (zero when nothing fits)
//   found       a coin was chosen
// ----------------------------------------------------------------------------
module change_dispenser_coin_select
    import change_dispenser_pkg::*;
#(
    parameter int NUM_COINS = CD_NUM_COINS,
    parameter int CALC_W    = 32
) (
    input  logic [NUM_COINS*COIN_W-1:0] coin_value,
    input  logic [CALC_W-1:0]           remaining,
    input  logic [NUM_COINS-1:0]        avail,
    output logic [NUM_COINS-1:0]        pick,
    output logic                        found
);

    logic [CALC_W-1:0] value;

    // Ascending scan: a later (larger index) match overrides an earlier one,
    // so the highest qualifying index wins. Zero-valued coins are skipped so
    // a request can never loop forever.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        value = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            value = CALC_W'(coin_value[i*COIN_W +: COIN_W]);
            if ((value != '0) && (value <= remaining) && avail[i]) begin
                pick    = '0;
                pick[i] = 1'b1;
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// ----------------------------------------------------------------------------
// change_dispenser
// Pays out a requested amount as a sequence of coins, largest first, one coin
// per hopper handshake, then reports any amount that could not be paid.
//
// Optional feature macro: CHANGE_INVENTORY_EN
//   defined   -> per-coin inventory counters, i_refill and o_inv_empty active
//   undefined -> unlimited inventory, i_refill ignored, o_inv_empty = 0
//
// Ports:
//   clk, reset_n        clock (rising edge), asynchronous active-low reset
//   i_req_valid/o_req_ready/i_req_amount   payout request
//   i_coin_value        packed coin values (32 bits each), index 0 smallest
//   o_dispense_valid/i_dispense_ready/o_dispense_coin   hopper eject (one-hot)
//   i_refill            per-coin refill pulse
//   o_inv_empty         per-coin inventory empty flag
//   o_done/o_remainder  one-cycle completion pulse with unpaid remainder
//   o_busy              high outside IDLE
//   o_state             current FSM state (debug)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Request side: o_req_ready is high only in IDLE. Hopper side:
// o_dispense_valid/o_dispense_coin are held stable until i_dispense_ready is
// sampled high; the coin is counted only on that edge.
// ----------------------------------------------------------------------------
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int NUM_COINS  = CD_NUM_COINS,
    parameter int TOTAL_BITS = 31,
    parameter int INV_BITS   = 8,
    parameter int INV_INIT   = 10
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        i_req_valid,
    input  logic [TOTAL_BITS-1:0]       i_req_amount,
    output logic                        o_req_ready,
    input  logic [NUM_COINS*COIN_W-1:0] i_coin_value,
    output logic [NUM_COINS-1:0]        o_dispense_coin,
    output logic                        o_dispense_valid,
    input  logic                        i_dispense_ready,
    input  logic [NUM_COINS-1:0]        i_refill,
    output logic [NUM_COINS-1:0]        o_inv_empty,
    output logic                        o_done,
    output logic [TOTAL_BITS-1:0]       o_remainder,
    output logic                        o_busy,
    output state_t                      o_state
);

    localparam int CALC_W = calc_width(TOTAL_BITS);

    state_t                 state, state_next;
    logic [TOTAL_BITS-1:0]  remaining, remaining_next;
    logic [NUM_COINS-1:0]   sel_coin, sel_coin_next;
    logic [NUM_COINS-1:0]   pick;
    logic [NUM_COINS-1:0]   avail;
    logic                   found;
    logic [CALC_W-1:0]      rem_wide;
    logic [CALC_W-1:0]      sel_value;
    logic [CALC_W-1:0]      diff_wide;
    logic                   handshake;
    logic                   unused_diff_msb;

    assign rem_wide  = CALC_W'(remaining);
    assign handshake = (state == ST_DISPENSE) && i_dispense_ready;

    // Value of the latched coin.
    always_comb begin
        sel_value = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (sel_coin[i]) begin
                sel_value = sel_value | CALC_W'(i_coin_value[i*COIN_W +: COIN_W]);
            end
        end
    end

    // Selection guarantees sel_value <= remaining, so the difference always
    // fits in TOTAL_BITS and the upper bits are zero.
    assign diff_wide       = rem_wide - sel_value;
    assign unused_diff_msb = ^diff_wide[CALC_W-1:TOTAL_BITS];

    change_dispenser_coin_select #(
        .NUM_COINS (NUM_COINS),
        .CALC_W    (CALC_W)
    ) coin_select (
        .coin_value (i_coin_value),
        .remaining  (rem_wide),
        .avail      (avail),
        .pick       (pick),
        .found      (found)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            remaining <= '0;
            sel_coin  <= '0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
            sel_coin  <= sel_coin_next;
        end
    end

    // Outputs decode the registered state only, so an asynchronous reset
    // drops o_dispense_valid immediately.
    always_comb begin
        state_next       = state;
        remaining_next   = remaining;
        sel_coin_next    = sel_coin;
        o_req_ready      = 1'b0;
        o_dispense_valid = 1'b0;
        o_dispense_coin  = '0;
        o_done           = 1'b0;
        o_remainder      = '0;
        case (state)
            ST_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    remaining_next = i_req_amount;
                    state_next     = ST_SELECT;
                end
            end
            ST_SELECT: begin
                if (found) begin
                    sel_coin_next = pick;
                    state_next    = ST_DISPENSE;
                end else begin
                    state_next = ST_DONE;
                end
            end
            ST_DISPENSE: begin
                o_dispense_valid = 1'b1;
                o_dispense_coin  = sel_coin;
                if (i_dispense_ready) begin
                    remaining_next = diff_wide[TOTAL_BITS-1:0];
                    state_next     = ST_SELECT;
                end
            end
            ST_DONE: begin
                o_done      = 1'b1;
                o_remainder = remaining;
                state_next  = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign o_busy  = (state != ST_IDLE);
    assign o_state = state;

    // ------------------------------------------------------------------
    // Inventory
    // ------------------------------------------------------------------
`ifdef CHANGE_INVENTORY_EN
    localparam logic [INV_BITS-1:0] INV_INIT_V = INV_BITS'(INV_INIT);

    logic [INV_BITS-1:0] inventory [NUM_COINS];

    // A refill wins over a decrement, but a coin ejected in the same cycle
    // is still taken out of the fresh load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_COINS; i++) begin
                inventory[i] <= INV_INIT_V;
            end
        end else begin
            for (int i = 0; i < NUM_COINS; i++) begin
                if (i_refill[i]) begin
                    inventory[i] <= (handshake && sel_coin[i]) ?
                                    INV_INIT_V - INV_BITS'(1) : INV_INIT_V;
                end else if (handshake && sel_coin[i] && (inventory[i] != '0)) begin
                    inventory[i] <= inventory[i] - INV_BITS'(1);
                end
            end
        end
    end

    always_comb begin
        avail = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            avail[i] = (inventory[i] != '0);
        end
    end

    assign o_inv_empty = ~avail;
`else
    localparam int unused_inv_cfg = INV_BITS + INV_INIT;

    logic unused_refill;

    assign avail         = '1;
    assign o_inv_empty   = '0;
    assign unused_refill = ^i_refill;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// ----------------------------------------------------------------------------
// tb_change_dispenser
// Directed self-checking bench for change_dispenser with coins 100/500/1000.
// Inputs are driven on the falling edge; outputs are sampled there too.
// ----------------------------------------------------------------------------
module tb_change_dispenser;
    import change_dispenser_pkg::*;

    localparam int NC = 3;
    localparam int TB = 31;

    logic              clk;
    logic              reset_n;
    logic              i_req_valid;
    logic [TB-1:0]     i_req_amount;
    logic              o_req_ready;
    logic [NC*32-1:0]  i_coin_value;
    logic [NC-1:0]     o_dispense_coin;
    logic              o_dispense_valid;
    logic              i_dispense_ready;
    logic [NC-1:0]     i_refill;
    logic [NC-1:0]     o_inv_empty;
    logic              o_done;
    logic [TB-1:0]     o_remainder;
    logic              o_busy;
    state_t            o_state;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [NC-1:0] exp_q[$];

    change_dispenser #(
        .NUM_COINS  (NC),
        .TOTAL_BITS (TB),
        .INV_BITS   (8),
        .INV_INIT   (10)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_req_valid      (i_req_valid),
        .i_req_amount     (i_req_amount),
        .o_req_ready      (o_req_ready),
        .i_coin_value     (i_coin_value),
        .o_dispense_coin  (o_dispense_coin),
        .o_dispense_valid (o_dispense_valid),
        .i_dispense_ready (i_dispense_ready),
        .i_refill         (i_refill),
        .o_inv_empty      (o_inv_empty),
        .o_done           (o_done),
        .o_remainder      (o_remainder),
        .o_busy           (o_busy),
        .o_state          (o_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; returns at the first SELECT sample.
    task automatic req(input logic [TB-1:0] amount);
        i_req_valid  = 1'b1;
        i_req_amount = amount;
        check("req_ready", 32'(o_req_ready), 1);
        @(negedge clk);
        i_req_valid  = 1'b0;
        i_req_amount = '0;
    endtask

    // Follow the transaction to o_done, matching ejected coins against exp_q.
    // Cycle 1 is the sample right after the call starts.
    task automatic run_to_done(input string tag, input int exp_cycles, input logic [TB-1:0] exp_rem);
        int cyc;
        logic got;
        got = 1'b0;
        for (cyc = 1; cyc <= 200; cyc++) begin
            if (o_dispense_valid && i_dispense_ready) begin
                if (exp_q.size() == 0) check({tag, " extra_coin"}, 32'(o_dispense_coin), 0);
                else check({tag, " coin"}, 32'(o_dispense_coin), 32'(exp_q.pop_front()));
            end
            if (o_done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, " done_seen"}, 32'(got), 1);
        check({tag, " done_cycle"}, 32'(cyc), 32'(exp_cycles));
        check({tag, " remainder"}, 32'(o_remainder), 32'(exp_rem));
        check({tag, " coins_missing"}, 32'(exp_q.size()), 0);
        exp_q.delete();
        @(negedge clk);
        check({tag, " done_one_cycle"}, 32'(o_done), 0);
        check({tag, " back_idle"}, 32'(o_state), 32'(ST_IDLE));
        check({tag, " ready_again"}, 32'(o_req_ready), 1);
    endtask

    initial begin
        reset_n          = 1'b0;
        i_req_valid      = 1'b0;
        i_req_amount     = '0;
        i_coin_value     = CD_DEFAULT_COIN_VALUES;
        i_dispense_ready = 1'b1;
        i_refill         = '0;

        // Reset state
        @(negedge clk);
        check("rst_ready", 32'(o_req_ready), 1);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_valid", 32'(o_dispense_valid), 0);
        check("rst_coin", 32'(o_dispense_coin), 0);
        check("rst_done", 32'(o_done), 0);
        check("rst_rem", 32'(o_remainder), 0);
        check("rst_empty", 32'(o_inv_empty), 0);
        check("rst_state", 32'(o_state), 32'(ST_IDLE));
        reset_n = 1'b1;
        @(negedge clk);

        // 1600 -> 1000, 500, 100
        req(31'd1600);
        check("r1600_busy", 32'(o_busy), 1);
        check("r1600_select", 32'(o_state), 32'(ST_SELECT));
        exp_q = '{3'b100, 3'b010, 3'b001};
        run_to_done("r1600", 8, 31'd0);

        // 250 -> 100, 100, remainder 50
        req(31'd250);
        exp_q = '{3'b001, 3'b001};
        run_to_done("r250", 6, 31'd50);

        // 0 -> done two cycles after acceptance, nothing ejected
        req(31'd0);
        run_to_done("r0", 2, 31'd0);

        // 50 -> below smallest coin
        req(31'd50);
        run_to_done("r50", 2, 31'd50);

        // 750 with hopper stalled 5 cycles on the first coin; a competing
        // request during the transaction must be ignored.
        i_dispense_ready = 1'b0;
        req(31'd750);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            i_req_valid  = 1'b1;
            i_req_amount = 31'd1000;
            check("stall_valid", 32'(o_dispense_valid), 1);
            check("stall_coin", 32'(o_dispense_coin), 32'(3'b010));
            check("stall_ready_low", 32'(o_req_ready), 0);
            @(negedge clk);
        end
        i_req_valid      = 1'b0;
        i_req_amount     = '0;
        i_dispense_ready = 1'b1;
        exp_q = '{3'b010, 3'b001, 3'b001};
        run_to_done("r750_stall", 7, 31'd50);

        // Zero-valued coin is never chosen
        i_coin_value = {32'd1000, 32'd0, 32'd100};
        req(31'd600);
        exp_q = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
        run_to_done("r600_zero_coin", 14, 31'd0);
        i_coin_value = CD_DEFAULT_COIN_VALUES;

        // Reset in the middle of a dispense
        i_dispense_ready = 1'b0;
        req(31'd1600);
        @(negedge clk);
        check("mid_valid", 32'(o_dispense_valid), 1);
        check("mid_coin", 32'(o_dispense_coin), 32'(3'b100));
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(o_dispense_valid), 0);
        check("mid_rst_state", 32'(o_state), 32'(ST_IDLE));
        check("mid_rst_busy", 32'(o_busy), 0);
        check("mid_rst_ready", 32'(o_req_ready), 1);
        check("mid_rst_empty", 32'(o_inv_empty), 0);
        @(negedge clk);
        reset_n          = 1'b1;
        i_dispense_ready = 1'b1;
        @(negedge clk);
        req(31'd500);
        exp_q = '{3'b010};
        run_to_done("r500_after_rst", 4, 31'd0);

`ifdef CHANGE_INVENTORY_EN
        // Drain the 500 inventory, then 1600 falls back to 1000 + 6 x 100
        i_refill = 3'b111;
        @(negedge clk);
        i_refill = '0;
        i_coin_value = {32'd0, 32'd500, 32'd100};
        req(31'd5000);
        for (int k = 0; k < 10; k++) exp_q.push_back(3'b010);
        run_to_done("drain500", 22, 31'd0);
        check("inv_empty_500", 32'(o_inv_empty), 32'(3'b010));
        i_coin_value = CD_DEFAULT_COIN_VALUES;
        req(31'd1600);
        exp_q = '{3'b100, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b001};
        run_to_done("r1600_no500", 16, 31'd0);
        check("inv_empty_after", 32'(o_inv_empty), 32'(3'b010));
        i_refill = 3'b010;
        @(negedge clk);
        i_refill = '0;
        check("inv_refill", 32'(o_inv_empty), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameters SHALL be: NUM_COINS, default 3, coin types; TOTAL_BITS, default 31, amount width; INV_BITS, default 8, inventory counter width; INV_INIT, default 10, reset/refill count per coin.
REQ-002 Ports SHALL be as follows; clock and reset are fixed: one clock, asynchronous active-low reset.
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- i_req_valid  input  1  return request.
- i_req_amount  input  TOTAL_BITS  amount to return.
- o_req_ready  output  1  request accepted when high with i_req_valid.
- i_coin_value  input  NUM_COINS*32  packed coin values, index 0 smallest.
- o_dispense_coin  output  NUM_COINS  one-hot coin to eject.
- o_dispense_valid  output  1  eject request to hopper.
- i_dispense_ready  input  1  hopper ejected coin.
- i_refill  input  NUM_COINS  per-coin refill pulse.
- o_inv_empty  output  NUM_COINS  inventory of coin i is zero.
- o_done  output  1  one-cycle completion pulse.
- o_remainder  output  TOTAL_BITS  amount not dispensable, valid while o_done is high.
- o_busy  output  1  high outside IDLE.

Function
REQ-003 The FSM SHALL have four states: IDLE, SELECT, DISPENSE, DONE.
REQ-004 In IDLE, o_req_ready SHALL be 1; when i_req_valid is high, the block SHALL latch i_req_amount into the remaining register and go to SELECT next cycle.
REQ-005 In SELECT, the block SHALL pick the highest index i where coin_value[i] != 0, coin_value[i] <= remaining, and inventory[i] > 0; if one is found it SHALL go to DISPENSE, otherwise to DONE.
REQ-006 In DISPENSE, o_dispense_valid SHALL be 1 and o_dispense_coin SHALL be one-hot of the chosen coin; both SHALL be held stable until i_dispense_ready is sampled high.
REQ-007 On the DISPENSE handshake, the block SHALL subtract coin_value[i] from remaining, decrement inventory[i], and return to SELECT; this gives a minimum of 2 cycles per coin.
REQ-008 DONE SHALL last one cycle, with o_done = 1 and o_remainder = remaining, then go to IDLE.
REQ-009 A request amount of 0 SHALL give o_done 2 cycles after acceptance, with remainder 0 and no dispense.
REQ-010 Coins of value 0 SHALL never be selected, which prevents an infinite loop.
REQ-011 Subtraction SHALL be unsigned at TOTAL_BITS and SHALL never underflow, because selection guarantees value <= remaining.
REQ-012 Inventory SHALL never decrement below 0.
REQ-013 An i_refill[i] pulse SHALL load INV_INIT in any state.
REQ-014 If refill and dispense hit the same coin in the same cycle, the result SHALL be INV_INIT-1.
REQ-015 o_inv_empty[i] SHALL equal (inventory[i]==0), registered-state derived with no extra latency.
REQ-016 i_req_valid SHALL be ignored outside IDLE.
REQ-017 o_dispense_valid and o_done SHALL be low outside DISPENSE and DONE respectively.

Reset
REQ-018 reset_n low SHALL immediately, independent of clk, set: state IDLE, remaining 0, every inventory INV_INIT, and all outputs 0 except o_req_ready=1 and o_inv_empty=0.
REQ-019 Reset mid-DISPENSE SHALL drop o_dispense_valid at once; the in-flight coin SHALL NOT be counted.

Configuration
REQ-020 With CHANGE_INVENTORY_EN defined, per-coin inventory counters, i_refill, and o_inv_empty SHALL be functional.
REQ-021 Without CHANGE_INVENTORY_EN, inventory SHALL be treated as unlimited: the REQ-005 inventory test is always true, i_refill is ignored, o_inv_empty is tied to 0, and no counters are synthesized.

Structure
REQ-022 State encoding, NUM_COINS, and default coin values (100, 500, 1000) SHALL live in the shared vending-machine definitions include.
REQ-023 Combinational coin selection (REQ-005) SHALL be a sub-module coin_select that outputs a one-hot pick and a found flag.

Verification (coins 100/500/1000, INV_INIT 10)
REQ-024 Request 1600 with ready tied to 1 -> coins 1000, 500, 100 in order; o_done with remainder 0; inventories 9/9/9.
REQ-025 Request 1600 with the 500 inventory at 0 (ifdef EN) -> 1000 then 100 x6; remainder 0; o_inv_empty[1]=1.
REQ-026 Request 250 -> 100, 100; remainder 50.
REQ-027 i_dispense_ready held low 5 cycles during DISPENSE -> valid and coin stable; no inventory or remaining change; single decrement on release.
REQ-028 reset_n asserted mid-DISPENSE of request 1600 -> valid=0 same cycle; state IDLE; inventories back to 10; a new request of 500 then completes normally.
REQ-029 Request 0 -> o_done exactly 2 cycles after acceptance, remainder 0; o_dispense_valid never high.
